sram_mem_controller: RTL
========================

// Module: sram_mem_controller
// PURPOSE
// - Sequences the MEM stage's data-memory access onto an external 16-bit asynchronous SRAM.
// - Each 32-bit word read or write is split into two half-word SRAM cycles.
// - Drives `freeze` into every pipeline stage register (including the MEM/WB register) so the pipeline stalls until the access finishes.
// - Sits between the EXE/MEM register outputs and the MEM/WB register inputs; sole master of the SRAM pins.
// PARAMETERS
// - SRAM_ADDR_W    18     SRAM half-word address width.
// - BASE_ADDR      1024   CPU byte address that maps to SRAM half-word 0.
// - ACCESS_CYCLES  2      clk cycles the SRAM signals are held per half-word access; must be >= 1.
// PORTS
// - clk            in   1            Single clock; all state changes on its rising edge.
// - rst            in   1            Asynchronous, active-high reset.
// - MEM_R_en       in   1            Load request, level; held by the pipeline while frozen.
// - MEM_W_en       in   1            Store request, level; held by the pipeline while frozen.
// - ALU_result     in   32           CPU byte address.
// - Val_Rm         in   32           Store data.
// - freeze         out  1            Stall to all pipeline registers.
// - ready          out  1            One-cycle pulse: the access is complete.
// - Mem_read_value out  32           Load result; valid while ready=1 and held until the next load.
// - SRAM_ADDR      out  SRAM_ADDR_W  Half-word address.
// - SRAM_DQ        io   16           Bidirectional data; driven only during write phases, else Z.
// - SRAM_WE_N      out  1            Write enable, active low.
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, ready=0, Mem_read_value=0, SRAM_ADDR=0, SRAM_WE_N=1, SRAM_DQ=Z, counter=0.
// - Address mapping: off = ALU_result - BASE_ADDR (32-bit, modulo 2^32).
//   SRAM_ADDR = {off[SRAM_ADDR_W:2], half}; half=0 selects the low 16 bits, half=1 the high 16 bits.
//   off[1:0] are ignored; out-of-range addresses wrap silently.
// - freeze = (MEM_R_en | MEM_W_en) & ~ready. This is combinational, so a request stalls in its first cycle.
// - State machine:
//   - IDLE: If MEM_W_en=1, latch addr/data, set op=WRITE, go to LOW. Else if MEM_R_en=1, latch addr, set op=READ, go to LOW.
//     Both asserted together: write wins. Neither asserted: stay.
//   - LOW: half=0, held for ACCESS_CYCLES cycles. WRITE drives SRAM_DQ=data[15:0], SRAM_WE_N=0.
//     READ samples SRAM_DQ into rdata[15:0] on the last cycle of the phase. Then go to HIGH.
//   - HIGH: Same as LOW with half=1 and data bits [31:16]. Then go to DONE.
//   - DONE: ready=1, SRAM_WE_N=1, DQ=Z. For a READ, Mem_read_value = rdata. Unconditionally return to IDLE next cycle.
// - Timing:
//   - Latency: request first seen at cycle 0 -> ready=1 at cycle 2*ACCESS_CYCLES+1.
//   - freeze is high for cycles 0..2*ACCESS_CYCLES and low in the ready cycle, so the pipeline advances.
//   - Back-to-back requests: the IDLE cycle after DONE starts the next access. No request is lost and none is started twice.
// - Stability:
//   - Inputs may change after latching without affecting the current access.
//   - SRAM_WE_N goes high in DONE before the address changes; no glitching writes.
//   - The phase counter wraps to 0 at each phase boundary.
// - Reset mid-access aborts it. The SRAM write may be partial; the pipeline is reset too.
// STRUCTURE
// - Shared package (mem_ctrl_pkg): state encoding IDLE/LOW/HIGH/DONE, op encoding READ/WRITE, default BASE_ADDR.
// - One sub-module, sram_phase_counter: counts 0..ACCESS_CYCLES-1 and pulses last_cycle. Everything else is inline.
// - SRAM_DQ tri-state is built from an internal dq_oe/dq_out pair.
// TESTING
// - Reset mid-HIGH of a write -> outputs return to reset values asynchronously; SRAM_WE_N=1, DQ=Z, state IDLE.
// - Store 0xDEADBEEF to ALU_result=1024+8 -> SRAM_ADDR 4 gets 0xBEEF, then 5 gets 0xDEAD.
//   With ACCESS_CYCLES=2: WE_N low for 2 cycles each, ready at cycle 5, freeze high for cycles 0..4.
// - Load from 1024+8 with an SRAM model -> Mem_read_value=0xDEADBEEF at ready; WE_N stays 1 throughout.
// - MEM_R_en and MEM_W_en both high -> a write is performed, with no read sampling.
// - Back-to-back store then load at the same address -> the second access starts the cycle after ready and reads back the stored word.
// - ALU_result=0 (below base) -> SRAM_ADDR wraps to {off[SRAM_ADDR_W:2],half} of 0xFFFFFC00; the access completes normally.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: state/op encodings and defaults.
// Also holds the CPU-address to SRAM-offset helper used by the top level.
package mem_ctrl_pkg;

    localparam int unsigned DefaultSramAddrW    = 18;
    localparam int unsigned DefaultBaseAddr     = 1024;
    localparam int unsigned DefaultAccessCycles = 2;

    typedef enum logic [1:0] {
        StIdle,
        StLow,
        StHigh,
        StDone
    } state_e;

    typedef enum logic {
        OpRead,
        OpWrite
    } op_e;

    // Byte offset into SRAM space; wraps modulo 2^32 for addresses below the base.
    function automatic logic [31:0] cpu_offset(input logic [31:0] addr, input int unsigned base);
        return addr - 32'(base);
    endfunction

endpackage

// File: rtl/sram_phase_counter.sv
// Counts the clk cycles of one half-word SRAM phase and flags its final cycle.
// The count wraps to zero on the last cycle so each phase starts from zero.
module sram_phase_counter #(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_last_cycle
);

    localparam int unsigned     CntW    = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(ACCESS_CYCLES - 1);

    logic [CntW-1:0] r_cnt;

    assign o_last_cycle = i_en && (r_cnt == LastCnt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_last_cycle ? '0 : r_cnt + CntW'(1);
        end
    end

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage data-memory controller: splits each 32-bit access into two half-word cycles
// on a 16-bit asynchronous SRAM and freezes the pipeline until the access completes.
module sram_mem_controller
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_ADDR_W   = DefaultSramAddrW,
    parameter int unsigned BASE_ADDR     = DefaultBaseAddr,
    parameter int unsigned ACCESS_CYCLES = DefaultAccessCycles
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   MEM_R_en,
    input  logic                   MEM_W_en,
    input  logic [31:0]            ALU_result,
    input  logic [31:0]            Val_Rm,
    output logic                   freeze,
    output logic                   ready,
    output logic [31:0]            Mem_read_value,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    inout  wire  [15:0]            SRAM_DQ,
    output logic                   SRAM_WE_N
);

    localparam int unsigned WordW = SRAM_ADDR_W - 1;

    state_e                   r_state;
    op_e                      r_op;
    logic [WordW-1:0]         r_word;
    logic [31:0]              r_wdata;
    logic [15:0]              r_rdata_lo;
    logic                     r_ready;
    logic [31:0]              r_mem_read_value;
    logic [SRAM_ADDR_W-1:0]   r_sram_addr;
    logic                     r_we_n;
    logic                     r_dq_oe;
    logic [15:0]              r_dq_out;

    logic [31:0]              w_off;
    logic [WordW-1:0]         w_word;
    logic                     w_unused_off;
    logic                     w_phase_en;
    logic                     w_last;

    assign w_off        = cpu_offset(ALU_result, BASE_ADDR);
    assign w_word       = w_off[SRAM_ADDR_W:2];
    assign w_unused_off = ^{w_off[31:SRAM_ADDR_W+1], w_off[1:0]};

    assign w_phase_en = (r_state == StLow) || (r_state == StHigh);

    sram_phase_counter #(
        .ACCESS_CYCLES (ACCESS_CYCLES)
    ) u_phase_counter (
        .clk          (clk),
        .rst          (rst),
        .i_en         (w_phase_en),
        .o_last_cycle (w_last)
    );

    // Combinational so a new request stalls the pipeline in its very first cycle.
    assign freeze         = (MEM_R_en | MEM_W_en) & ~r_ready;
    assign ready          = r_ready;
    assign Mem_read_value = r_mem_read_value;
    assign SRAM_ADDR      = r_sram_addr;
    assign SRAM_WE_N      = r_we_n;
    assign SRAM_DQ        = r_dq_oe ? r_dq_out : 16'hzzzz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state          <= StIdle;
            r_op             <= OpRead;
            r_word           <= '0;
            r_wdata          <= '0;
            r_rdata_lo       <= '0;
            r_ready          <= 1'b0;
            r_mem_read_value <= '0;
            r_sram_addr      <= '0;
            r_we_n           <= 1'b1;
            r_dq_oe          <= 1'b0;
            r_dq_out         <= '0;
        end else begin
            r_ready <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    // Write has priority when both requests are raised together.
                    if (MEM_W_en) begin
                        r_op        <= OpWrite;
                        r_word      <= w_word;
                        r_wdata     <= Val_Rm;
                        r_sram_addr <= {w_word, 1'b0};
                        r_we_n      <= 1'b0;
                        r_dq_oe     <= 1'b1;
                        r_dq_out    <= Val_Rm[15:0];
                        r_state     <= StLow;
                    end else if (MEM_R_en) begin
                        r_op        <= OpRead;
                        r_word      <= w_word;
                        r_sram_addr <= {w_word, 1'b0};
                        r_we_n      <= 1'b1;
                        r_dq_oe     <= 1'b0;
                        r_state     <= StLow;
                    end
                end
                StLow: begin
                    if (w_last) begin
                        if (r_op == OpRead) begin
                            r_rdata_lo <= SRAM_DQ;
                        end
                        r_sram_addr <= {r_word, 1'b1};
                        r_dq_out    <= r_wdata[31:16];
                        r_state     <= StHigh;
                    end
                end
                StHigh: begin
                    if (w_last) begin
                        if (r_op == OpRead) begin
                            r_mem_read_value <= {SRAM_DQ, r_rdata_lo};
                        end
                        // Release WE_N and the bus while the address is still stable.
                        r_we_n  <= 1'b1;
                        r_dq_oe <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

endmodule
